rd_drain_arb: RTL

RD_DRAIN_ARB -- requirements
Module: rd_drain_arb

---
 rtl/fifo_arb_pkg.sv | 19 +
 rtl/rr_pick.sv | 32 +++
 rtl/rd_drain_arb.sv | 112 +++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the read-side FIFO drain arbiter.
// The channel and burst-counter widths are derived from the module parameters.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic int ch_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // One spare bit so the counter can represent BURST_MAX itself.
    function automatic int burst_width(input int bmax);
        return $clog2(bmax) + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: the first set request at or after i_start,
// wrapping modulo N.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = ch_width(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_start,
    output logic [W-1:0] o_idx,
    output logic         o_found
);

    always_comb begin : pick_search
        int j;
        o_idx   = '0;
        o_found = 1'b0;
        // Walk from the farthest candidate back to i_start so the nearest one wins.
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(i_start) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (i_req[j]) begin
                o_idx   = W'(j);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rd_drain_arb.sv
// Drains several async-FIFO read ports into one valid/ready stream, serving the
// channels round-robin in bursts of up to BURST_MAX words per grant.
module rd_drain_arb
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_CH     = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int BURST_MAX  = 4,
    localparam int CHW        = ch_width(NUM_CH),
    localparam int BCW        = burst_width(BURST_MAX)
) (
    input  logic                                rclk,
    input  logic                                rrst,
    input  logic                                en,
    input  logic [NUM_CH-1:0]                   rempty,
    input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]   rdata,
    output logic [NUM_CH-1:0]                   rinc,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [DATA_WIDTH-1:0]               out_data,
    output logic [CHW-1:0]                      out_ch,
    output logic                                busy
);

    arb_state_t            r_state;
    logic [CHW-1:0]        r_gnt;
    logic [CHW-1:0]        r_rr_ptr;
    logic [BCW-1:0]        r_burst_cnt;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [CHW-1:0]        r_out_ch;

    logic [NUM_CH-1:0]     w_req;
    logic [CHW-1:0]        w_pick_idx;
    logic                  w_pick_found;
    logic                  w_gnt_empty;
    logic                  w_pop;
    logic                  w_last;
    logic [CHW-1:0]        w_next_ptr;

    assign w_req = ~rempty;

    rr_pick #(
        .N (NUM_CH),
        .W (CHW)
    ) u_pick (
        .i_req   (w_req),
        .i_start (r_rr_ptr),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

    assign w_gnt_empty = rempty[r_gnt];
    // A pop needs a word at the head and room in the single output register.
    assign w_pop       = (r_state == GRANT) && !w_gnt_empty && (!r_out_valid || out_ready);
    assign w_last      = (r_burst_cnt == BCW'(BURST_MAX - 1));
    assign w_next_ptr  = (r_gnt == CHW'(NUM_CH - 1)) ? '0 : r_gnt + CHW'(1);

    always_comb begin
        rinc = '0;
        if (w_pop) begin
            rinc[r_gnt] = 1'b1;
        end
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
        end else begin
            if (w_pop) begin
                r_out_data  <= rdata[r_gnt];
                r_out_ch    <= r_gnt;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (en && w_pick_found) begin
                        r_gnt       <= w_pick_idx;
                        r_burst_cnt <= '0;
                        r_state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_pop) begin
                        r_burst_cnt <= r_burst_cnt + BCW'(1);
                    end
                    // en is deliberately ignored here: a started burst always runs out.
                    if (w_gnt_empty || (w_pop && w_last)) begin
                        r_state  <= IDLE;
                        r_rr_ptr <= w_next_ptr;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign busy      = (r_state == GRANT);

endmodule
